// File: rtl/inst_fetch_queue_if.sv
// Bus bundle for inst_fetch_queue.
// It groups the PC-stage request, the instruction-memory grant/response
// handshake, and the decode-side valid/ready queue head.
// slave  : the fetch queue side.
// master : the environment side, which holds the PC stage, memory and decode.
interface inst_fetch_queue_if;
    logic [63:0] inst_addr;
    logic        inst_ena;
    logic        if_stall;
    logic        flush;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic        id_misalign;

    modport slave (
        input  inst_addr, inst_ena, flush, mem_gnt, mem_rvalid, mem_rdata, id_ready,
        output if_stall, mem_req, mem_addr, id_valid, id_pc, id_inst, id_misalign
    );

    modport master (
        output inst_addr, inst_ena, flush, mem_gnt, mem_rvalid, mem_rdata, id_ready,
        input  if_stall, mem_req, mem_addr, id_valid, id_pc, id_inst, id_misalign
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: issues one fetch at a time to instruction memory and
// queues the returned words, each with its PC, in a DEPTH-entry FIFO for decode.
// A queue slot is reserved for every outstanding fetch, so the FIFO cannot overflow.
// A flush empties the queue. A fetch that is still in flight is marked killed,
// and its response is dropped when it arrives.
// Optional feature: define FETCH_MISALIGN_CHK_EN to enable the misaligned-fetch check.
module inst_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_KREQ  = 3'd3,
        ST_KWAIT = 3'd4
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             mem_req_r;
    logic [63:0]      mem_addr_r;
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [63:0]      pc_q_r   [DEPTH];
    logic [31:0]      inst_q_r [DEPTH];

    logic             inflight_s, space_s, accept_s, issue_s;
    logic             rsp_push_s, push_s, pop_s;
    logic [CNT_W:0]   occ_s;
    logic [63:0]      push_pc_s;
    logic [31:0]      push_inst_s;

`ifdef FETCH_MISALIGN_CHK_EN
    logic             misal_q_r [DEPTH];
    logic             addr_ok_s, misal_push_s;
    assign addr_ok_s    = (bus.inst_addr[1:0] == 2'b00);
    assign issue_s      = accept_s & addr_ok_s;
    assign misal_push_s = accept_s & ~addr_ok_s;
`else
    assign issue_s      = accept_s;
`endif

    // An outstanding live fetch holds a slot. A same-cycle pop is not credited.
    assign inflight_s = (state_r == ST_REQ) || (state_r == ST_WAIT);
    assign occ_s      = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_s};
    assign space_s    = (occ_s < DEPTH_C);

    // Accept a new fetch address when idle, or when the current response completes.
    always_comb begin
        accept_s = 1'b0;
        if (bus.inst_ena && !bus.flush && space_s) begin
            if (state_r == ST_IDLE) begin
                accept_s = 1'b1;
            end else if ((state_r == ST_WAIT) && bus.mem_rvalid) begin
`ifdef FETCH_MISALIGN_CHK_EN
                accept_s = addr_ok_s;
`else
                accept_s = 1'b1;
`endif
            end else begin
                accept_s = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Stall the PC stage whenever it offers an address that cannot be taken.
    always_comb begin
        bus.if_stall = 1'b0;
        if (rst) begin
            bus.if_stall = 1'b0;
        end else begin
            bus.if_stall = bus.inst_ena & ~accept_s;
        end
    end

    // Select the FIFO push source: a memory response, or a misaligned-fetch marker.
    always_comb begin
        rsp_push_s  = (state_r == ST_WAIT) && bus.mem_rvalid && !bus.flush;
`ifdef FETCH_MISALIGN_CHK_EN
        push_s      = rsp_push_s | misal_push_s;
`else
        push_s      = rsp_push_s;
`endif
        pop_s       = (count_r != {CNT_W{1'b0}}) && bus.id_ready;
        push_pc_s   = rsp_push_s ? mem_addr_r : bus.inst_addr;
        push_inst_s = rsp_push_s ? bus.mem_rdata : 32'h0000_0000;
    end

    // Compute the next fetch state. A flush kills any fetch that is still in flight.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) state_nxt_s = ST_REQ;
                else         state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                // A grant in the flush cycle means memory already owes a response.
                if (bus.flush)        state_nxt_s = bus.mem_gnt ? ST_KWAIT : ST_KREQ;
                else if (bus.mem_gnt) state_nxt_s = ST_WAIT;
                else                  state_nxt_s = ST_REQ;
            end
            ST_WAIT: begin
                if (bus.flush)           state_nxt_s = bus.mem_rvalid ? ST_IDLE : ST_KWAIT;
                else if (bus.mem_rvalid) state_nxt_s = issue_s ? ST_REQ : ST_IDLE;
                else                     state_nxt_s = ST_WAIT;
            end
            ST_KREQ: begin
                if (bus.mem_gnt) state_nxt_s = ST_KWAIT;
                else             state_nxt_s = ST_KREQ;
            end
            ST_KWAIT: begin
                if (bus.mem_rvalid) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_KWAIT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Register the state, the request strobe and the request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 64'h0;
        end else begin
            state_r   <= state_nxt_s;
            mem_req_r <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_KREQ);
            if (issue_s) mem_addr_r <= bus.inst_addr;
            else         mem_addr_r <= mem_addr_r;
        end
    end

    // Update the FIFO storage, pointers and occupancy. A flush clears the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]    <= 64'h0;
                inst_q_r[i]  <= 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
                misal_q_r[i] <= 1'b0;
`endif
            end
        end else if (bus.flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                pc_q_r[wr_ptr_r]    <= push_pc_s;
                inst_q_r[wr_ptr_r]  <= push_inst_s;
`ifdef FETCH_MISALIGN_CHK_EN
                misal_q_r[wr_ptr_r] <= ~rsp_push_s;
`endif
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.id_valid = (count_r != {CNT_W{1'b0}});
    assign bus.id_pc    = pc_q_r[rd_ptr_r];
    assign bus.id_inst  = inst_q_r[rd_ptr_r];
`ifdef FETCH_MISALIGN_CHK_EN
    assign bus.id_misalign = misal_q_r[rd_ptr_r];
`else
    assign bus.id_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH = 4).
// Inputs change on the falling edge, and outputs are sampled 1 time unit later.
// The misalignment scenario follows FETCH_MISALIGN_CHK_EN.
module tb_inst_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic        auto_mem = 1'b0;
    logic        pend_v   = 1'b0;
    logic [31:0] pend_a   = 32'h0;

    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Advance to the next falling edge.
    // In auto mode, act as a zero-wait memory: grant always, respond one cycle later.
    task automatic tick();
        @(negedge clk);
        if (auto_mem) begin
            bus.mem_rvalid = pend_v;
            bus.mem_rdata  = 32'h13 + pend_a;
            bus.mem_gnt    = 1'b1;
            pend_v         = bus.mem_req;
            pend_a         = bus.mem_addr[31:0];
        end
    endtask

    task automatic quiet_mem();
        auto_mem = 1'b0; pend_v = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.inst_ena = 1'b1; bus.inst_addr = 64'h40; bus.flush = 1'b0;
        bus.id_ready = 1'b0; quiet_mem();
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req c%0d: got %b want 0", c, bus.mem_req); end
            n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid c%0d: got %b want 0", c, bus.id_valid); end
            n_chk++; if (bus.if_stall !== 1'b0) begin n_fail++; $display("FAIL reset_if_stall c%0d: got %b want 0", c, bus.if_stall); end
            n_chk++; if (bus.id_pc !== 64'h0) begin n_fail++; $display("FAIL reset_id_pc c%0d: got %h want 0", c, bus.id_pc); end
            n_chk++; if (bus.mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr c%0d: got %h want 0", c, bus.mem_addr); end
            n_chk++; if (bus.id_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_id_misalign c%0d: got %b want 0", c, bus.id_misalign); end
        end
        tick(); rst = 1'b0; bus.inst_ena = 1'b0;
    endtask

    task automatic test_stream();
        logic [8:0] e_stall, e_valid, e_req;
        int idx;
        logic [63:0] pc;
        e_stall = 9'b000001010;
        e_valid = 9'b010101000;
        e_req   = 9'b000101010;
        idx = 0; bus.id_ready = 1'b1; auto_mem = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            bus.inst_ena  = (idx < 3);
            bus.inst_addr = 64'(idx * 4);
            #1;
            n_chk++; if (bus.if_stall !== e_stall[c]) begin n_fail++; $display("FAIL stream_stall c%0d: got %b want %b", c, bus.if_stall, e_stall[c]); end
            n_chk++; if (bus.id_valid !== e_valid[c]) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, bus.id_valid, e_valid[c]); end
            n_chk++; if (bus.mem_req !== e_req[c]) begin n_fail++; $display("FAIL stream_req c%0d: got %b want %b", c, bus.mem_req, e_req[c]); end
            if (e_valid[c]) begin
                pc = 64'(((c - 3) / 2) * 4);
                n_chk++; if (bus.id_pc !== pc) begin n_fail++; $display("FAIL stream_pc c%0d: got %h want %h", c, bus.id_pc, pc); end
                n_chk++; if (bus.id_inst !== 32'h13 + pc[31:0]) begin n_fail++; $display("FAIL stream_inst c%0d: got %h want %h", c, bus.id_inst, 32'h13 + pc[31:0]); end
            end
            if (bus.inst_ena && !bus.if_stall) idx++;
        end
        bus.inst_ena = 1'b0; bus.id_ready = 1'b0; quiet_mem();
    endtask

    task automatic test_backpressure();
        int idx, grants, accepts;
        idx = 0; grants = 0; accepts = 0; bus.id_ready = 1'b0; auto_mem = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            bus.inst_ena = 1'b1; bus.inst_addr = 64'h100 + 64'(idx * 4);
            #1;
            if (bus.mem_req && bus.mem_gnt) grants++;
            if (c >= 9) begin
                n_chk++; if (bus.if_stall !== 1'b1) begin n_fail++; $display("FAIL bp_full_stall c%0d: got %b want 1", c, bus.if_stall); end
                n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_no_5th_req c%0d: got %b want 0", c, bus.mem_req); end
            end
            if (bus.inst_ena && !bus.if_stall) idx++;
        end
        n_chk++; if (grants !== 4) begin n_fail++; $display("FAIL bp_grants: got %0d want 4", grants); end
        n_chk++; if (bus.id_pc !== 64'h100) begin n_fail++; $display("FAIL bp_head_pc: got %h want 100", bus.id_pc); end
        n_chk++; if (bus.id_inst !== 32'h113) begin n_fail++; $display("FAIL bp_head_inst: got %h want 113", bus.id_inst); end
        for (int c = 0; c < 8; c++) begin
            tick();
            bus.id_ready = (c == 0); bus.inst_ena = 1'b1; bus.inst_addr = 64'h100 + 64'(idx * 4);
            #1;
            if (bus.inst_ena && !bus.if_stall) begin accepts++; idx++; end
        end
        n_chk++; if (accepts !== 1) begin n_fail++; $display("FAIL bp_one_more_accept: got %0d want 1", accepts); end
        n_chk++; if (bus.id_pc !== 64'h104) begin n_fail++; $display("FAIL bp_head_after_pop: got %h want 104", bus.id_pc); end
        n_chk++; if (bus.if_stall !== 1'b1) begin n_fail++; $display("FAIL bp_refull_stall: got %b want 1", bus.if_stall); end
        tick(); bus.id_ready = 1'b0; bus.inst_ena = 1'b0; bus.flush = 1'b1;
        tick(); bus.flush = 1'b0; #1;
        n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL bp_flush_empty: got %b want 0", bus.id_valid); end
        quiet_mem();
    endtask

    task automatic test_flush_wait();
        tick(); bus.inst_ena = 1'b1; bus.inst_addr = 64'h200; #1;
        n_chk++; if (bus.if_stall !== 1'b0) begin n_fail++; $display("FAIL fw_accept: got %b want 0", bus.if_stall); end
        tick(); bus.inst_ena = 1'b0; bus.mem_gnt = 1'b1; #1;
        n_chk++; if (bus.mem_addr !== 64'h200) begin n_fail++; $display("FAIL fw_mem_addr: got %h want 200", bus.mem_addr); end
        tick(); bus.mem_gnt = 1'b0; bus.flush = 1'b1; #1;
        n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL fw_wait_req: got %b want 0", bus.mem_req); end
        tick(); bus.flush = 1'b0; bus.inst_ena = 1'b1; bus.inst_addr = 64'h300; #1;
        n_chk++; if (bus.if_stall !== 1'b1) begin n_fail++; $display("FAIL fw_kwait_stall: got %b want 1", bus.if_stall); end
        n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fw_valid_after_flush: got %b want 0", bus.id_valid); end
        tick(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hdeadbeef; #1;
        n_chk++; if (bus.if_stall !== 1'b1) begin n_fail++; $display("FAIL fw_stall_on_drop: got %b want 1", bus.if_stall); end
        tick(); bus.mem_rvalid = 1'b0; #1;
        n_chk++; if (bus.if_stall !== 1'b0) begin n_fail++; $display("FAIL fw_accept_after_drop: got %b want 0", bus.if_stall); end
        n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fw_no_push: got %b want 0", bus.id_valid); end
        tick(); bus.inst_ena = 1'b0; bus.mem_gnt = 1'b1; #1;
        n_chk++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL fw_new_req: got %b want 1", bus.mem_req); end
        n_chk++; if (bus.mem_addr !== 64'h300) begin n_fail++; $display("FAIL fw_new_addr: got %h want 300", bus.mem_addr); end
        tick(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h313; #1;
        n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fw_no_bypass: got %b want 0", bus.id_valid); end
        tick(); bus.mem_rvalid = 1'b0; bus.id_ready = 1'b1; #1;
        n_chk++; if (bus.id_pc !== 64'h300) begin n_fail++; $display("FAIL fw_head_pc: got %h want 300", bus.id_pc); end
        n_chk++; if (bus.id_inst !== 32'h313) begin n_fail++; $display("FAIL fw_head_inst: got %h want 313", bus.id_inst); end
        tick(); bus.id_ready = 1'b0; #1;
        n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fw_popped: got %b want 0", bus.id_valid); end
    endtask

    task automatic test_flush_req();
        tick(); bus.inst_ena = 1'b1; bus.inst_addr = 64'h400;
        tick(); bus.inst_ena = 1'b0; bus.flush = 1'b1; #1;
        n_chk++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL fr_req: got %b want 1", bus.mem_req); end
        for (int c = 0; c < 4; c++) begin
            tick(); bus.flush = 1'b0; bus.inst_ena = 1'b1; bus.inst_addr = 64'h500; bus.mem_gnt = (c == 3); #1;
            n_chk++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL fr_req_held c%0d: got %b want 1", c, bus.mem_req); end
            n_chk++; if (bus.mem_addr !== 64'h400) begin n_fail++; $display("FAIL fr_addr_held c%0d: got %h want 400", c, bus.mem_addr); end
            n_chk++; if (bus.if_stall !== 1'b1) begin n_fail++; $display("FAIL fr_stall c%0d: got %b want 1", c, bus.if_stall); end
        end
        tick(); bus.mem_gnt = 1'b0; #1;
        n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL fr_req_drop: got %b want 0", bus.mem_req); end
        tick(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000bad; #1;
        n_chk++; if (bus.if_stall !== 1'b1) begin n_fail++; $display("FAIL fr_stall_drop: got %b want 1", bus.if_stall); end
        tick(); bus.mem_rvalid = 1'b0; #1;
        n_chk++; if (bus.if_stall !== 1'b0) begin n_fail++; $display("FAIL fr_accept: got %b want 0", bus.if_stall); end
        n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fr_discarded: got %b want 0", bus.id_valid); end
        tick(); bus.inst_ena = 1'b0; bus.mem_gnt = 1'b1; #1;
        n_chk++; if (bus.mem_addr !== 64'h500) begin n_fail++; $display("FAIL fr_new_addr: got %h want 500", bus.mem_addr); end
        tick(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h513;
        tick(); bus.mem_rvalid = 1'b0; bus.id_ready = 1'b1; #1;
        n_chk++; if (bus.id_pc !== 64'h500) begin n_fail++; $display("FAIL fr_head_pc: got %h want 500", bus.id_pc); end
        n_chk++; if (bus.id_inst !== 32'h513) begin n_fail++; $display("FAIL fr_head_inst: got %h want 513", bus.id_inst); end
        tick(); bus.id_ready = 1'b0; #1;
        n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fr_popped: got %b want 0", bus.id_valid); end
    endtask

    task automatic test_misalign();
        tick(); bus.inst_ena = 1'b1; bus.inst_addr = 64'h102; #1;
        n_chk++; if (bus.if_stall !== 1'b0) begin n_fail++; $display("FAIL ma_accept: got %b want 0", bus.if_stall); end
`ifdef FETCH_MISALIGN_CHK_EN
        tick(); bus.inst_ena = 1'b0; bus.id_ready = 1'b1; #1;
        n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL ma_no_req: got %b want 0", bus.mem_req); end
        n_chk++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL ma_valid: got %b want 1", bus.id_valid); end
        n_chk++; if (bus.id_pc !== 64'h102) begin n_fail++; $display("FAIL ma_pc: got %h want 102", bus.id_pc); end
        n_chk++; if (bus.id_misalign !== 1'b1) begin n_fail++; $display("FAIL ma_flag: got %b want 1", bus.id_misalign); end
        n_chk++; if (bus.id_inst !== 32'h0) begin n_fail++; $display("FAIL ma_inst: got %h want 0", bus.id_inst); end
`else
        tick(); bus.inst_ena = 1'b0; bus.mem_gnt = 1'b1; #1;
        n_chk++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL ma_req: got %b want 1", bus.mem_req); end
        n_chk++; if (bus.mem_addr !== 64'h102) begin n_fail++; $display("FAIL ma_addr: got %h want 102", bus.mem_addr); end
        tick(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h115;
        tick(); bus.mem_rvalid = 1'b0; bus.id_ready = 1'b1; #1;
        n_chk++; if (bus.id_pc !== 64'h102) begin n_fail++; $display("FAIL ma_pc: got %h want 102", bus.id_pc); end
        n_chk++; if (bus.id_inst !== 32'h115) begin n_fail++; $display("FAIL ma_inst: got %h want 115", bus.id_inst); end
        n_chk++; if (bus.id_misalign !== 1'b0) begin n_fail++; $display("FAIL ma_flag: got %b want 0", bus.id_misalign); end
`endif
        tick(); bus.id_ready = 1'b0; #1;
        n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL ma_popped: got %b want 0", bus.id_valid); end
    endtask

    // Run all scenarios in sequence, then report.
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_wait();
        test_flush_req();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Fetch-side request and buffer stage between the PC generator and decode. It accepts one fetch address per handshake from the PC stage (`inst_addr`/`inst_ena`) and issues it to instruction memory over a grant/response handshake. Returned instruction words are queued with their PC in a DEPTH-entry FIFO and presented to decode with valid/ready. It stalls the PC stage when no slot can be reserved, and supports pipeline flush.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk` in 1, clock; all logic on rising edge.
- `rst` in 1, synchronous, active-high reset.
- `inst_addr` in 64, fetch address from the PC stage.
- `inst_ena` in 1, fetch address valid.
- `if_stall` out 1, PC stage must hold `inst_addr` next cycle.
- `flush` in 1, discard queue and any outstanding fetch.
- `mem_req` out 1, memory request valid.
- `mem_addr` out 64, request address.
- `mem_gnt` in 1, request accepted this cycle.
- `mem_rvalid` in 1, response valid.
- `mem_rdata` in 32, response instruction.
- `id_valid` out 1, queue head valid.
- `id_ready` in 1, decode consumes head.
- `id_pc` out 64, head PC.
- `id_inst` out 32, head instruction.
- `id_misalign` out 1, head carries misaligned-fetch flag; tied 0 when the check is compiled out.

## Operation
- FSM states:
  - IDLE.
  - REQ: `mem_req`=1.
  - WAIT: awaiting response.
  - KREQ: killed, awaiting grant, `mem_req`=1.
  - KWAIT: killed, awaiting response.
- inflight = state ∈ {REQ, WAIT}. space = (count + inflight) < DEPTH, where count is the registered occupancy. A same-cycle pop is not credited.
- accept = `inst_ena` & !`flush` & space & (state==IDLE | (state==WAIT & `mem_rvalid`)).
- On accept, `inst_addr` is latched into `mem_addr` and next state is REQ.
- `if_stall` = `inst_ena` & !accept.
- REQ: `mem_addr` is held stable until `mem_gnt`, then WAIT. `mem_req` is never withdrawn before grant.
- WAIT with `mem_rvalid`:
  - push {`mem_addr`, `mem_rdata`, 0}.
  - Next state is REQ if accept, else IDLE.
- Memory returns exactly one `mem_rvalid` per grant, no earlier than the cycle after `mem_gnt`. `mem_rvalid` is ignored in IDLE and REQ.
- Pop: `id_valid` & `id_ready`. Pop advances the head pointer.
- `id_valid` = (count != 0). The head fields read directly from the array; there is no push→head bypass.
- Push and pop in the same cycle: count is unchanged, both pointers advance. Pointers wrap modulo DEPTH. Overflow is impossible by construction (reservation).
- `flush`, highest priority:
  - count and pointers go to 0; no push that cycle.
  - REQ→KREQ, WAIT→KWAIT. WAIT with `mem_rvalid` the same cycle → IDLE, response dropped.
  - KREQ→KWAIT on grant. KWAIT→IDLE on `mem_rvalid`, response discarded.
  - No accept occurs in K states.
- Reset: state IDLE; count and pointers 0; all array entries 0.
  - Output values during and after reset: `mem_req`=0, `mem_addr`=0, `id_valid`=0, `id_pc`=0, `id_inst`=0, `id_misalign`=0.
  - `if_stall` is forced 0 while `rst`.
  - Memory shares `rst`; reset mid-transaction abandons it with no drain.

## Timing
- Accept at cycle t → `mem_req` high at t+1.
- With grant at t+1 and response at t+2, the entry is pushed at the end of t+2 and `id_valid`=1 at t+3.
- Sustained throughput with zero-wait memory: one instruction per 2 cycles.
- `if_stall` is combinational from `inst_ena`, `flush`, `mem_rvalid` and the registered state.
- Flush takes effect at the next edge. `id_valid` is 0 the cycle after `flush`.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - An accept in IDLE with `inst_addr[1:0]` != 0 issues no memory request and stays in IDLE.
  - At that edge it pushes {`inst_addr`, 32'h0, 1}.
  - Misaligned addresses are not accepted in WAIT; `if_stall`=1 there until IDLE.
- Macro undefined:
  - No alignment check; all 64 address bits pass to `mem_addr`.
  - `id_misalign` is constant 0 and the FIFO carries no flag bit.

## Test plan
- Reset: hold `rst` 2 cycles with `inst_ena`=1 → `mem_req`=0, `id_valid`=0, `if_stall`=0, `id_pc`=0, `mem_addr`=0.
- Zero-wait stream, setup:
  - addrs 0x0, 0x4, 0x8; `mem_gnt` always 1; `mem_rvalid` the cycle after grant with `mem_rdata`=0x13+addr; `id_ready`=1.
  - Response: `id_pc` 0x0, 0x4, 0x8 in order; first `id_valid` 3 cycles after accept; then one entry every 2 cycles.
- Backpressure (`DEPTH`=4, `id_ready`=0):
  - Exactly 4 grants occur, then `if_stall`=1 with no 5th `mem_req`.
  - A single pop → exactly one further accept.
- Flush in WAIT, `mem_rvalid` delayed 3 cycles:
  - Nothing is pushed and `id_valid` stays 0.
  - The next accept happens only in the cycle after the discarded response.
- Flush in REQ with grant withheld 4 cycles:
  - `mem_req` stays 1 and `mem_addr` is unchanged until grant.
  - The response is then discarded.
- With `FETCH_MISALIGN_CHK_EN`, addr 0x102 in IDLE → no `mem_req`; next cycle `id_valid`=1, `id_pc`=0x102, `id_misalign`=1, `id_inst`=0. Without the macro → `mem_addr`=0x102.
